// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit right-shifting LFSR generator and checker:
// word width, feedback taps, checker state encoding and the next-word function.
package lfsr_pkg;

    localparam int LFSR_W = 16;

    // Feedback taps; the XOR of these bits enters at the MSB on every step.
    localparam int TAP0 = 0;
    localparam int TAP1 = 2;
    localparam int TAP2 = 3;
    localparam int TAP3 = 5;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] w);
        return {w[TAP0] ^ w[TAP1] ^ w[TAP2] ^ w[TAP3], w[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr_checker_step.sv
// Combinational single LFSR step: next_word = next(word).
module lfsr_checker_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] word,
    output logic [LFSR_W-1:0] next_word
);

    assign next_word = lfsr_next(word);

endmodule

// File: rtl/lfsr_checker.sv
// Receiver-side LFSR sequence checker. Seeds a predictor from the incoming
// stream (HUNT/VERIFY), then flywheels it in LOCKED and flags/counts words that
// break the sequence.
// Optional feature macro: LFSR_CHK_AUTORESYNC_EN -- when defined, MISS_LIMIT
// consecutive mismatches in LOCKED drop the checker back to HUNT.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_LEN   = 4,
    parameter int MISS_LIMIT = 3,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              resync,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] in_word,
    output logic              locked,
    output logic              match_pulse,
    output logic              err_pulse,
    output logic              zero_flag,
    output logic [CNT_W-1:0]  err_count
);

    // Elaboration-time range checks on the configuration.
    if (LOCK_LEN < 1 || LOCK_LEN > 15) begin : g_bad_lock_len
        $error("lfsr_checker: LOCK_LEN must be in 1..15");
    end
    if (MISS_LIMIT < 1 || MISS_LIMIT > 15) begin : g_bad_miss_limit
        $error("lfsr_checker: MISS_LIMIT must be in 1..15");
    end

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_LEN - 1);
`ifdef LFSR_CHK_AUTORESYNC_EN
    localparam logic [3:0] MISS_LIM  = 4'(MISS_LIMIT);
`endif

    chk_state_t        state, state_nx;
    logic [LFSR_W-1:0] pred, pred_nx;
    logic [3:0]        good_cnt, good_nx;
    logic [3:0]        miss_cnt, miss_nx, miss_inc;
    logic [CNT_W-1:0]  err_count_nx;
    logic              match_nx, err_nx, zero_nx;

    logic [LFSR_W-1:0] seed_next;
    logic [LFSR_W-1:0] fly_next;
    logic              is_zero;
    logic              is_match;

    // Seed path: prediction derived from the observed word (HUNT/VERIFY).
    lfsr_checker_step u_step_seed (
        .word      (in_word),
        .next_word (seed_next)
    );

    // Flywheel path: prediction advanced from itself (LOCKED).
    lfsr_checker_step u_step_fly (
        .word      (pred),
        .next_word (fly_next)
    );

    assign is_zero  = (in_word == '0);
    assign is_match = (in_word == pred);
    assign miss_inc = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;
    assign locked   = (state == ST_LOCKED);

    // State, predictor, counters and registered pulse outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_HUNT;
            pred        <= '0;
            good_cnt    <= '0;
            miss_cnt    <= '0;
            err_count   <= '0;
            match_pulse <= 1'b0;
            err_pulse   <= 1'b0;
            zero_flag   <= 1'b0;
        end else begin
            state       <= state_nx;
            pred        <= pred_nx;
            good_cnt    <= good_nx;
            miss_cnt    <= miss_nx;
            err_count   <= err_count_nx;
            match_pulse <= match_nx;
            err_pulse   <= err_nx;
            zero_flag   <= zero_nx;
        end
    end

    // Next-state, predictor update and pulse decode for one valid sample.
    always_comb begin
        state_nx     = state;
        pred_nx      = pred;
        good_nx      = good_cnt;
        miss_nx      = miss_cnt;
        err_count_nx = err_count;
        match_nx     = 1'b0;
        err_nx       = 1'b0;
        zero_nx      = 1'b0;

        if (resync) begin
            // A sample coinciding with resync is dropped entirely.
            state_nx = ST_HUNT;
            good_nx  = '0;
            miss_nx  = '0;
        end else if (in_valid) begin
            zero_nx = is_zero;
            unique case (state)
                ST_HUNT: begin
                    if (!is_zero) begin
                        pred_nx  = seed_next;
                        good_nx  = '0;
                        state_nx = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (is_zero) begin
                        good_nx  = '0;
                        state_nx = ST_HUNT;
                    end else if (is_match) begin
                        pred_nx = seed_next;
                        good_nx = good_cnt + 4'd1;
                        if (good_cnt == LOCK_LAST) begin
                            miss_nx  = '0;
                            state_nx = ST_LOCKED;
                        end
                    end else begin
                        // Reseed from the word just seen and restart the count.
                        pred_nx = seed_next;
                        good_nx = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: never reseed, so a single bad word keeps phase.
                    pred_nx = fly_next;
                    if (is_match) begin
                        match_nx = 1'b1;
                        miss_nx  = '0;
                    end else begin
                        err_nx  = 1'b1;
                        miss_nx = miss_inc;
                        if (!(&err_count)) begin
                            err_count_nx = err_count + 1'b1;
                        end
`ifdef LFSR_CHK_AUTORESYNC_EN
                        if (miss_inc == MISS_LIM) begin
                            state_nx = ST_HUNT;
                            good_nx  = '0;
                            miss_nx  = '0;
                        end
`endif
                    end
                end
                default: begin
                    state_nx = ST_HUNT;
                    good_nx  = '0;
                    miss_nx  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

    localparam int LOCK_LEN   = 4;
    localparam int MISS_LIMIT = 3;
    localparam int CNT_W      = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        resync;
    logic        in_valid;
    logic [15:0] in_word;
    logic        locked;
    logic        match_pulse;
    logic        err_pulse;
    logic        zero_flag;
    logic [CNT_W-1:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integers, modes by name.
    localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;
    int m_mode, m_pred, m_good, m_miss, m_cnt;
    int e_match, e_err, e_zero;

    // Stream generator word.
    logic [15:0] g;

    always #5 clk = ~clk;

    lfsr_checker #(
        .LOCK_LEN   (LOCK_LEN),
        .MISS_LIMIT (MISS_LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .resync      (resync),
        .in_valid    (in_valid),
        .in_word     (in_word),
        .locked      (locked),
        .match_pulse (match_pulse),
        .err_pulse   (err_pulse),
        .zero_flag   (zero_flag),
        .err_count   (err_count)
    );

    function automatic int nxt(input int w);
        int fb;
        fb = ((w >> 0) ^ (w >> 2) ^ (w >> 3) ^ (w >> 5)) & 1;
        return ((w >> 1) | (fb << 15)) & 16'hFFFF;
    endfunction

    function automatic logic [15:0] bad_word(input logic [15:0] good);
        logic [15:0] w;
        w = 16'(($urandom % 16'hFFFF) + 1);
        if (w == good) w = good ^ 16'h0040;
        if (w == 16'h0000) w = 16'h0001;
        return w;
    endfunction

    task automatic model_reset();
        m_mode = M_HUNT; m_pred = 0; m_good = 0; m_miss = 0; m_cnt = 0;
        e_match = 0; e_err = 0; e_zero = 0;
    endtask

    task automatic model_step(input bit v, input int w, input bit rs);
        e_match = 0; e_err = 0; e_zero = 0;
        if (rs) begin
            m_mode = M_HUNT; m_good = 0; m_miss = 0;
        end else if (v) begin
            e_zero = (w == 0);
            if (m_mode == M_HUNT) begin
                if (w != 0) begin
                    m_pred = nxt(w); m_good = 0; m_mode = M_VERIFY;
                end
            end else if (m_mode == M_VERIFY) begin
                if (w == 0) begin
                    m_mode = M_HUNT; m_good = 0;
                end else if (w == m_pred) begin
                    m_pred = nxt(w);
                    m_good = m_good + 1;
                    if (m_good == LOCK_LEN) begin
                        m_mode = M_LOCKED; m_miss = 0;
                    end
                end else begin
                    m_pred = nxt(w); m_good = 0;
                end
            end else begin
                if (w == m_pred) begin
                    e_match = 1; m_miss = 0;
                end else begin
                    e_err = 1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
                    if (m_miss < 15) m_miss = m_miss + 1;
`ifdef LFSR_CHK_AUTORESYNC_EN
                    if (m_miss == MISS_LIMIT) begin
                        m_mode = M_HUNT; m_good = 0; m_miss = 0;
                    end
`endif
                end
                m_pred = nxt(m_pred);
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked"},      32'(locked),      32'(m_mode == M_LOCKED));
        check({tag, ".match_pulse"}, 32'(match_pulse), 32'(e_match));
        check({tag, ".err_pulse"},   32'(err_pulse),   32'(e_err));
        check({tag, ".zero_flag"},   32'(zero_flag),   32'(e_zero));
        check({tag, ".err_count"},   32'(err_count),   32'(m_cnt));
    endtask

    // One clock: drive on the falling edge, update model at the rising edge,
    // compare 1 time unit later.
    task automatic cycle(input string tag, input bit v, input logic [15:0] w, input bit rs);
        @(negedge clk);
        in_valid = v; in_word = w; resync = rs;
        @(posedge clk);
        model_step(v, int'(w), rs);
        #1;
        check_all(tag);
    endtask

    // Send the next correct stream word and advance the generator.
    task automatic send_good(input string tag);
        cycle(tag, 1'b1, g, 1'b0);
        g = 16'(nxt(int'(g)));
    endtask

    task automatic send_bad(input string tag);
        cycle(tag, 1'b1, bad_word(g), 1'b0);
        g = 16'(nxt(int'(g)));
    endtask

    initial begin
        rst = 1'b0; resync = 1'b0; in_valid = 1'b0; in_word = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Lock onto the stream starting at 0xACE1.
        g = 16'hACE1;
        for (int i = 0; i < 5; i++) begin
            send_good("lock");
            if (i == 3) check("not_locked_after_4", 32'(locked), 32'd0);
        end
        check("locked_after_5", 32'(locked), 32'd1);
        check("no_err_at_lock", 32'(err_count), 32'd0);

        // Single corrupted word, flywheel keeps phase.
        cycle("corrupt", 1'b1, 16'h1234, 1'b0);
        g = 16'(nxt(int'(g)));
        check("corrupt_err", 32'(err_pulse), 32'd1);
        check("corrupt_cnt", 32'(err_count), 32'd1);
        send_good("resume");
        check("resume_match", 32'(match_pulse), 32'd1);

        // Three consecutive wrong words.
        for (int i = 0; i < 3; i++) send_bad("miss3");
`ifdef LFSR_CHK_AUTORESYNC_EN
        check("autoresync_drop", 32'(locked), 32'd0);
        for (int i = 0; i < LOCK_LEN + 1; i++) send_good("relock");
        check("autoresync_relock", 32'(locked), 32'd1);
`else
        check("no_autoresync", 32'(locked), 32'd1);
`endif

        // Zero word while locked.
        cycle("zero_locked", 1'b1, 16'h0000, 1'b0);
        g = 16'(nxt(int'(g)));
        check("zero_locked_zf", 32'(zero_flag), 32'd1);
        check("zero_locked_err", 32'(err_pulse), 32'd1);

        // resync together with a valid word.
        cycle("resync", 1'b1, g, 1'b1);
        check("resync_unlocked", 32'(locked), 32'd0);
        check("resync_no_match", 32'(match_pulse), 32'd0);

        // Zero word in HUNT.
        cycle("zero_hunt", 1'b1, 16'h0000, 1'b0);
        check("zero_hunt_zf", 32'(zero_flag), 32'd1);

        // Lock with idle gaps between valid words.
        for (int i = 0; i < LOCK_LEN + 1; i++) begin
            send_good("gap_valid");
            repeat (1 + (i % 3)) cycle("gap_idle", 1'b0, 16'(bad_word(g)), 1'b0);
        end
        check("gap_locked", 32'(locked), 32'd1);

`ifndef LFSR_CHK_AUTORESYNC_EN
        // Counter saturation.
        for (int i = 0; i < (1 << CNT_W) + 5; i++) send_bad("sat");
        check("sat_count", 32'(err_count), 32'hFF);
        check("sat_locked", 32'(locked), 32'd1);
`endif

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_locked", 32'(locked), 32'd0);
        check("async_cnt", 32'(err_count), 32'd0);
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < LOCK_LEN + 1; i++) send_good("post_reset_lock");
        check("post_reset_locked", 32'(locked), 32'd1);

        // Randomized traffic: gaps, corruptions, zero words and resyncs.
        for (int i = 0; i < 3000; i++) begin
            bit v, rs;
            logic [15:0] w;
            v  = ($urandom % 4) != 0;
            rs = ($urandom % 97) == 0;
            w  = g;
            if (($urandom % 12) == 0) w = (($urandom % 6) == 0) ? 16'h0000 : bad_word(g);
            cycle("random", v, w, rs);
            if (v) g = 16'(nxt(int'(g)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
